dii_stream_src: RTL
===================

Name: dii_stream_src

Overview:
- DII instruction source directly upstream of the DII interface block; drives the instruction word the core fetch FIFO consumes in DII simulation.
- Buffers a host-supplied instruction stream (TestRIG-style valid/ready) in a FIFO and presents the head word.
- Pads with a NOP when starved, pops on fetch ack, tracks issue/retire counts and signals end-of-test once the pipeline has drained.

Parameters:
Depth, 16, FIFO entries (power of 2, >=2)
NopInsn, 32'h0000_0013, pad word (addi x0,x0,0) driven when FIFO empty
DrainRetire, 4, pad-instruction retirements required in DRAIN before done

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-high
in_valid_i  in  1  host word valid
in_ready_o  out  1  FIFO can accept
in_insn_i  in  32  host instruction word
in_last_i  in  1  qualifies in_valid_i: final word of test
dii_insn_o  out  32  instruction presented to fetch (FIFO head or NopInsn)
dii_ack_i  in  1  fetch consumed dii_insn_o this cycle
rvfi_valid_i  in  1  instruction retired
rvfi_trap_i  in  1  retired instruction trapped (qualified by rvfi_valid_i)
done_o  out  1  test complete, sticky until reset
err_o  out  1  sticky: retirement with zero outstanding
issue_cnt_o  out  32  acked FIFO words (excl. pads)
pad_cnt_o  out  32  acked pad words
retire_cnt_o  out  32  rvfi_valid_i count
trap_cnt_o  out  32  trapped retirement count

Behaviour:
- Reset (rst_ni=1, async): FIFO empty, pointers 0, state IDLE, all counters 0, done_o=0, err_o=0, in_ready_o=0, dii_insn_o=NopInsn.
- FIFO: log2(Depth)+1-bit rd/wr pointers, wrap naturally; full when MSBs differ and LSBs equal. in_ready_o = !full and state in {IDLE,STREAM}; registered-storage read, no push-to-head bypass (pushed word visible on dii_insn_o next cycle at earliest).
- Push when in_valid_i & in_ready_o. Pop when dii_ack_i & !empty; issue_cnt_o+1. dii_ack_i & empty: no pop, pad_cnt_o+1.
- Simultaneous push+pop: both occur, occupancy unchanged. Push+ack while empty: ack counts as pad, word stored.
- dii_insn_o = empty ? NopInsn : mem[rd_ptr]; stable until ack.
- Outstanding counter (log2(Depth)+8 bits): +1 per ack (FIFO or pad), -1 per rvfi_valid_i; both same cycle: unchanged. rvfi_valid_i with outstanding 0 and no ack that cycle: err_o=1, counter held at 0.
- trap_cnt_o +1 on rvfi_valid_i & rvfi_trap_i; trap does not alter FIFO (core refetch consumes new stream words).
- All 32-bit counters wrap 0xFFFF_FFFF -> 0.
- FSM:
  - IDLE: -> STREAM on first push.
  - STREAM: -> LAST on push with in_last_i=1.
  - LAST: in_ready_o=0; -> DRAIN when FIFO empty; clear drain counter.
  - DRAIN: drain counter +1 per rvfi_valid_i; -> DONE when counter reaches DrainRetire.
  - DONE: done_o=1; further acks still return NopInsn and count pads; no exit except reset.
- Reset asserted mid-operation: immediate return to reset values; in-flight FIFO contents discarded.

Test Plan:
- Reset: assert rst_ni mid-stream with 5 words queued -> dii_insn_o=0x00000013, in_ready_o=0, all counters 0 same cycle.
- Stream: push 0x00100093,0x00200113 (last on 2nd), ack each cycle, retire each -> dii_insn_o sequence 0x00100093,0x00200113,then 0x13; issue_cnt_o=2; done_o after 4 pad retirements.
- Full: push 16 words with no ack -> in_ready_o=0 after 16th; one ack -> in_ready_o=1 next cycle; 17th word accepted, order preserved.
- Starve: ack 3 cycles with FIFO empty -> pad_cnt_o=3, issue_cnt_o=0, outstanding=3.
- Simultaneous push+ack at occupancy 1 -> occupancy stays 1, head advances to pushed word.
- Error/trap: rvfi_valid_i with outstanding 0 -> err_o=1 sticky; rvfi_valid_i&rvfi_trap_i twice -> trap_cnt_o=2, FIFO unchanged.

Source files
------------

// File: rtl/dii_stream_src.sv
// DII instruction source: buffers a host instruction stream in a FIFO,
// presents the head word to fetch (or a NOP pad when starved), tracks
// issue/pad/retire/trap counts and raises done once the pipeline drains.
module dii_stream_src #(
  parameter int unsigned Depth       = 16,
  parameter logic [31:0] NopInsn     = 32'h0000_0013,
  parameter int unsigned DrainRetire = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_insn_i,
  input  logic        in_last_i,
  output logic [31:0] dii_insn_o,
  input  logic        dii_ack_i,
  input  logic        rvfi_valid_i,
  input  logic        rvfi_trap_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] issue_cnt_o,
  output logic [31:0] pad_cnt_o,
  output logic [31:0] retire_cnt_o,
  output logic [31:0] trap_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned OW = AW + 8;
  localparam int unsigned DW = $clog2(DrainRetire + 1);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    LAST,
    DRAIN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;

  logic [31:0]   mem [Depth];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] outstanding_q;

  logic empty, full, accepting;
  logic push, pop, pad_ack;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign accepting = (state_q == IDLE) || (state_q == STREAM);

  // Ready is forced low while reset is held so the host sees no acceptance.
  assign in_ready_o = !rst_ni && !full && accepting;

  assign push    = in_valid_i && in_ready_o;
  assign pop     = dii_ack_i && !empty;
  assign pad_ack = dii_ack_i && empty;

  // Head word straight from storage; a word pushed this cycle shows up next cycle.
  assign dii_insn_o = empty ? NopInsn : mem[rd_ptr_q[AW-1:0]];
  assign done_o     = (state_q == DONE);

  // FIFO storage write.
  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= in_insn_i;
    end
  end

  // FIFO read/write pointers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Outstanding instructions (acked but not yet retired) and the sticky underflow error.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      outstanding_q <= '0;
      err_o         <= 1'b0;
    end else if (dii_ack_i && !rvfi_valid_i) begin
      outstanding_q <= outstanding_q + OW'(1);
    end else if (!dii_ack_i && rvfi_valid_i) begin
      if (outstanding_q == '0) begin
        err_o <= 1'b1;
      end else begin
        outstanding_q <= outstanding_q - OW'(1);
      end
    end
  end

  // Statistics counters; all wrap naturally at 32 bits.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      issue_cnt_o  <= '0;
      pad_cnt_o    <= '0;
      retire_cnt_o <= '0;
      trap_cnt_o   <= '0;
    end else begin
      if (pop)                         issue_cnt_o  <= issue_cnt_o + 32'd1;
      if (pad_ack)                     pad_cnt_o    <= pad_cnt_o + 32'd1;
      if (rvfi_valid_i)                retire_cnt_o <= retire_cnt_o + 32'd1;
      if (rvfi_valid_i && rvfi_trap_i) trap_cnt_o   <= trap_cnt_o + 32'd1;
    end
  end

  // Test-phase state register and drain retirement counter.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Test-phase sequencing: stream until the last word, wait for the FIFO to
  // empty, then count pad retirements until the pipeline is drained.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        // A single-word test can carry the last flag on its first word.
        if (push) state_d = in_last_i ? LAST : STREAM;
      end
      STREAM: begin
        if (push && in_last_i) state_d = LAST;
      end
      LAST: begin
        if (empty) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (rvfi_valid_i) begin
          drain_d = drain_q + DW'(1);
          if (drain_q == DW'(DrainRetire - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
